// File: rtl/mata_poly_reader.sv
// mata_poly_reader: streams one 256-coefficient polynomial A[k][l] out of the
// packed matrix-A RAM, one coefficient per handshake. A two-word prefetch
// buffer hides the RAM read latency and absorbs downstream backpressure.
module mata_poly_reader #(
  parameter int K                    = 8,
  parameter int L                    = 7,
  parameter int COEFF_WIDTH          = 24,
  parameter int COEFF_PER_WORD       = 4,
  parameter int NTT_ADDR_WIDTH       = 12,
  parameter int MATRIX_A_BASE_OFFSET = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [2:0]                            k_idx,
  input  logic [2:0]                            l_idx,
  output logic [NTT_ADDR_WIDTH-1:0]             addr_matA,
  input  logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] dout_matA,
  output logic [COEFF_WIDTH-1:0]                coeff_out,
  output logic                                  coeff_valid,
  input  logic                                  coeff_ready,
  output logic                                  coeff_last,
  output logic [7:0]                            coeff_idx,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int WORD_W         = COEFF_WIDTH * COEFF_PER_WORD;
  localparam int WORDS_PER_POLY = 256 / COEFF_PER_WORD;
  localparam int WCNT_W         = $clog2(WORDS_PER_POLY);
  localparam int SEL_W          = $clog2(COEFF_PER_WORD);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [NTT_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [NTT_ADDR_WIDTH-1:0]   addr_q;
  logic [WCNT_W-1:0]           w_q;
  logic [7:0]                  idx_q;
  logic                        s1_q, s2_q;   // read issued / read data on dout_matA
  logic [WORD_W-1:0]           buf_q [2];
  logic                        wr_ptr_q, rd_ptr_q;
  logic [1:0]                  buf_cnt_q, buf_cnt_d;
  logic                        err_q;

  logic                        accept, bad_start, issue, hs, pop;
  logic [2:0]                  occupancy;
  logic [SEL_W-1:0]            sel;
  logic [WORD_W-1:0]           head_word;
  logic [COEFF_WIDTH-1:0]      lanes [COEFF_PER_WORD];

  assign sel       = idx_q[SEL_W-1:0];
  assign head_word = buf_q[rd_ptr_q];

  // Split the head buffer word into its coefficient lanes, lane 0 in the LSBs.
  for (genvar gi = 0; gi < COEFF_PER_WORD; gi++) begin : g_lane
    assign lanes[gi] = head_word[gi*COEFF_WIDTH +: COEFF_WIDTH];
  end

  assign coeff_valid = (buf_cnt_q != 2'd0);
  assign coeff_out   = coeff_valid ? lanes[sel] : '0;
  assign coeff_idx   = idx_q;
  assign coeff_last  = coeff_valid && (idx_q == 8'd255);
  assign hs          = coeff_valid && coeff_ready;
  assign pop         = hs && (sel == SEL_W'(COEFF_PER_WORD - 1));
  assign addr_matA   = addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;

  // Words held plus words still travelling through the RAM pipeline.
  assign occupancy = {1'b0, buf_cnt_q} + {2'b0, s1_q} + {2'b0, s2_q};
  assign buf_cnt_d = buf_cnt_q + {1'b0, s2_q} - {1'b0, pop};
  assign base_d    = NTT_ADDR_WIDTH'(MATRIX_A_BASE_OFFSET +
                     (int'(k_idx) * L + int'(l_idx)) * WORDS_PER_POLY);

  // Next-state logic: start handling, read issue throttling and completion.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    bad_start = 1'b0;
    issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((int'(k_idx) < K) && (int'(l_idx) < L)) begin
            accept  = 1'b1;
            state_d = S_READ;
          end else begin
            bad_start = 1'b1;
          end
        end
      end
      S_READ: begin
        issue = (occupancy < 3'd2);
        if (issue && (w_q == WCNT_W'(WORDS_PER_POLY - 1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (hs && (idx_q == 8'd255)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath: address generation, read pipeline, prefetch buffer, counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q    <= '0;
      addr_q    <= '0;
      w_q       <= '0;
      idx_q     <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      buf_cnt_q <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= base_d;
        w_q    <= '0;
        idx_q  <= '0;
      end else if (hs) begin
        idx_q <= idx_q + 8'd1;
      end
      if (issue) begin
        addr_q <= base_q + NTT_ADDR_WIDTH'(w_q);
        w_q    <= w_q + 1'b1;
      end
      s1_q <= issue;
      s2_q <= s1_q;
      if (s2_q) begin
        buf_q[wr_ptr_q] <= dout_matA;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      buf_cnt_q <= buf_cnt_d;
      err_q     <= bad_start;
    end
  end

endmodule
